ehr_rr_sched: RTL and testbench

Round-robin write-port scheduler for a P-port EHR (ephemeral history register). It shares the EHR's P ordered write ports among R requesters. Each cycle it grants up to P active requesters and maps them, in fair rotating order, onto EHR ports 0..P-1. Port order is significant: a higher port observes and overrides lower ports within the cycle. The block sits between requester logic and the EHR, drives the EHR's `wd`/`wv` directly, and keeps grant statistics.

---
 rtl/ehr_rr_sched_if.sv | 19 +
 rtl/ehr_rr_sched.sv | 45 ++++
 tb/tb_ehr_rr_sched.sv | 105 ++++++++++
 3 files changed

// File: rtl/ehr_rr_sched_if.sv
// ehr_rr_sched_if: requester/EHR-side bundle of the round-robin EHR write-port scheduler
interface ehr_rr_sched_if #(
  parameter int R = 4,
  parameter int P = 2,
  parameter int N = 32
);
  localparam int W = $clog2(R);
  logic                  en;
  logic [R-1:0]          req;
  logic [R-1:0][N-1:0]   req_data;
  logic [R-1:0]          gnt;
  logic [P-1:0][N-1:0]   ehr_wd;
  logic [P-1:0]          ehr_wv;
  logic [W-1:0]          rr_ptr;
  logic [31:0]           grant_cnt;
  logic [31:0]           full_cnt;
  modport master (output en, req, req_data, input gnt, ehr_wd, ehr_wv, rr_ptr, grant_cnt, full_cnt);
  modport slave  (input en, req, req_data, output gnt, ehr_wd, ehr_wv, rr_ptr, grant_cnt, full_cnt);
endinterface

// File: rtl/ehr_rr_sched.sv
// ehr_rr_sched: maps up to P requesters per cycle, in rotating order, onto ordered EHR write ports
module ehr_rr_sched #(
  parameter int R = 4,
  parameter int P = 2,
  parameter int N = 32
) (
  input logic clk,
  input logic rst_n,
  ehr_rr_sched_if.slave bus
);
  localparam int W = $clog2(R);
  int n;
  int last;
  logic [32:0] gc_sum;
  always_comb begin
    bus.gnt = '0;
    bus.ehr_wd = '0;
    bus.ehr_wv = '0;
    n = 0;
    last = 0;
    for (int k = 0; k < R; k++)
      for (int i = 0; i < R; i++)
        if (rst_n && bus.en && bus.req[i] && n < P && i == (int'(bus.rr_ptr) + k) % R) begin
          bus.gnt[i] = 1'b1;
          last = i;
          for (int p = 0; p < P; p++)
            if (p == n) begin
              bus.ehr_wd[p] = bus.req_data[i];
              bus.ehr_wv[p] = 1'b1;
            end
          n = n + 1;
        end
  end
  assign gc_sum = {1'b0, bus.grant_cnt} + 33'(n);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rr_ptr <= '0;
      bus.grant_cnt <= '0;
      bus.full_cnt <= '0;
    end else if (n != 0) begin
      bus.rr_ptr <= W'((last + 1) % R);
      bus.grant_cnt <= gc_sum[32] ? '1 : gc_sum[31:0];
      if (n == P && bus.full_cnt != '1) bus.full_cnt <= bus.full_cnt + 32'd1;
    end
endmodule

// File: tb/tb_ehr_rr_sched.sv
// tb_ehr_rr_sched: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_ehr_rr_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0]  g;
    logic [1:0]  wv;
    logic [31:0] w0, w1;
    logic [1:0]  p;
    logic [31:0] gc, fc;
  } exp_t;
  exp_t sb[$];
  ehr_rr_sched_if #(.R(4), .P(2), .N(32)) bus ();
  ehr_rr_sched #(.R(4), .P(2), .N(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic vec(input logic r, input logic e, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] wv, input logic [31:0] w0, input logic [31:0] w1,
                     input logic [1:0] p, input logic [31:0] gc, input logic [31:0] fc);
    @(posedge clk);
    #1;
    rst_n = r;
    bus.en = e;
    bus.req = rq;
    sb.push_back('{g, wv, w0, w1, p, gc, fc});
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("gnt", 32'(bus.gnt), 32'(e.g));
        chk("ehr_wv", 32'(bus.ehr_wv), 32'(e.wv));
        chk("ehr_wd0", bus.ehr_wd[0], e.w0);
        chk("ehr_wd1", bus.ehr_wd[1], e.w1);
        chk("rr_ptr", 32'(bus.rr_ptr), 32'(e.p));
        chk("grant_cnt", bus.grant_cnt, e.gc);
        chk("full_cnt", bus.full_cnt, e.fc);
      end
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin : stim
    bus.en = 1'b1;
    bus.req = 4'b1111;
    bus.req_data[0] = 32'h11;
    bus.req_data[1] = 32'h22;
    bus.req_data[2] = 32'hA5;
    bus.req_data[3] = 32'h44;
    //   rst en req     gnt      wv     wd0    wd1    ptr  gcnt  fcnt
    vec(0, 1, 4'b1111, 4'b0000, 2'b00, 32'h0,  32'h0,  0, 0,  0);
    vec(1, 1, 4'b0100, 4'b0100, 2'b01, 32'hA5, 32'h0,  0, 0,  0);
    vec(1, 1, 4'b1000, 4'b1000, 2'b01, 32'h44, 32'h0,  3, 1,  0);
    vec(1, 1, 4'b1111, 4'b0011, 2'b11, 32'h11, 32'h22, 0, 2,  0);
    vec(1, 1, 4'b1111, 4'b1100, 2'b11, 32'hA5, 32'h44, 2, 4,  1);
    vec(1, 1, 4'b1111, 4'b0011, 2'b11, 32'h11, 32'h22, 0, 6,  2);
    vec(1, 1, 4'b1111, 4'b1100, 2'b11, 32'hA5, 32'h44, 2, 8,  3);
    vec(1, 1, 4'b0100, 4'b0100, 2'b01, 32'hA5, 32'h0,  0, 10, 4);
    vec(1, 1, 4'b1001, 4'b1001, 2'b11, 32'h44, 32'h11, 3, 11, 4);
    vec(1, 0, 4'b1111, 4'b0000, 2'b00, 32'h0,  32'h0,  1, 13, 5);
    vec(1, 0, 4'b1111, 4'b0000, 2'b00, 32'h0,  32'h0,  1, 13, 5);
    vec(1, 0, 4'b1111, 4'b0000, 2'b00, 32'h0,  32'h0,  1, 13, 5);
    vec(1, 1, 4'b0000, 4'b0000, 2'b00, 32'h0,  32'h0,  1, 13, 5);
    vec(1, 1, 4'b0000, 4'b0000, 2'b00, 32'h0,  32'h0,  1, 13, 5);
    vec(1, 1, 4'b1111, 4'b0110, 2'b11, 32'h22, 32'hA5, 1, 13, 5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(bus.gnt), 32'h0);
    chk("async_wv", 32'(bus.ehr_wv), 32'h0);
    chk("async_wd0", bus.ehr_wd[0], 32'h0);
    chk("async_wd1", bus.ehr_wd[1], 32'h0);
    chk("async_ptr", 32'(bus.rr_ptr), 32'h0);
    chk("async_gcnt", bus.grant_cnt, 32'h0);
    chk("async_fcnt", bus.full_cnt, 32'h0);
    vec(1, 1, 4'b0000, 4'b0000, 2'b00, 32'h0,  32'h0,  0, 0,  0);
    @(negedge clk);
    #1;
    force bus.grant_cnt = 32'hFFFF_FFFE;
    #1;
    release bus.grant_cnt;
    vec(1, 1, 4'b0011, 4'b0011, 2'b11, 32'h11, 32'h22, 0, 32'hFFFF_FFFE, 0);
    vec(1, 1, 4'b0000, 4'b0000, 2'b00, 32'h0,  32'h0,  2, 32'hFFFF_FFFF, 1);
    vec(1, 1, 4'b0001, 4'b0001, 2'b01, 32'h11, 32'h0,  2, 32'hFFFF_FFFF, 1);
    vec(1, 1, 4'b0000, 4'b0000, 2'b00, 32'h0,  32'h0,  1, 32'hFFFF_FFFF, 1);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
